// File: rtl/contador_descendente_if.sv
// Control/status bundle for the synchronous down counter.
//   cant_ff  : stage mask; bit i=0 forces num[i] to 0
//   en       : count enable (only acts in RUN)
//   load     : synchronous load strobe, has priority over en
//   load_val : value to load, masked by cant_ff
//   one_shot : 1 = stop in HOLD at zero, 0 = wrap and keep counting
//   num      : registered count
//   tc       : one-cycle pulse when a decrement lands on zero
//   busy     : counter is in RUN
//   done     : counter is in HOLD
interface contador_descendente_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] cant_ff;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             one_shot;
  logic [WIDTH-1:0] num;
  logic             tc;
  logic             busy;
  logic             done;

  modport master (
    output cant_ff, en, load, load_val, one_shot,
    input  num, tc, busy, done
  );

  modport slave (
    input  cant_ff, en, load, load_val, one_shot,
    output num, tc, busy, done
  );
endinterface

// File: rtl/contador_descendente.sv
// Synchronous, masked, loadable down counter usable as a timer or divider.
// All stages update on the same clk edge.
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : contador_descendente_if.slave (mask, en/load/one_shot controls,
//         num/tc/busy/done status, all outputs registered)
module contador_descendente #(
  parameter int WIDTH = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  contador_descendente_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_num,   w_num_nxt;
  logic             r_tc,    w_tc_nxt;
  logic [WIDTH-1:0] w_load_m;
  logic [WIDTH-1:0] w_dec;

  // Masked load value; the borrow of the decrement runs through masked-off
  // bits before the mask is applied, which is what skips unused codes.
  assign w_load_m = bus.load_val & bus.cant_ff;
  assign w_dec    = WIDTH'(r_num - 1'b1) & bus.cant_ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_num   <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_num   <= w_num_nxt;
      r_tc    <= w_tc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_num_nxt   = r_num & bus.cant_ff;   // holding still tracks mask changes
    w_tc_nxt    = 1'b0;
    if (bus.load) begin
      // Same rule from every state; a one-shot load of zero has nothing to
      // count so it parks directly in HOLD.
      w_num_nxt   = w_load_m;
      w_state_nxt = (bus.one_shot && (w_load_m == '0)) ? S_HOLD : S_RUN;
    end else if ((r_state == S_RUN) && bus.en) begin
      if (r_num == '0) begin
        // Wrap: continuous mode, or zero reached through a mask change.
        w_num_nxt = bus.cant_ff;
      end else begin
        w_num_nxt = w_dec;
        if (w_dec == '0) begin
          w_tc_nxt = 1'b1;
          if (bus.one_shot) w_state_nxt = S_HOLD;
        end
      end
    end
  end

  assign bus.num  = r_num;
  assign bus.tc   = r_tc;
  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_HOLD);

endmodule
